// File: rtl/multicycle_control_unit_if.sv
// Fetch / datapath / memory signal bundle for the multicycle control unit.
// slave = the control unit, master = whoever drives instructions and memory status.
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 11,
    parameter int ALUOP_W  = 2,
    parameter int RET_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                ins_valid;
    logic                ins_ready;
    logic                zero;
    logic                mem_ready;
    logic                trap_clr;
    logic                reg2loc;
    logic                alusrc;
    logic                memtoreg;
    logic                regwrite;
    logic                memread;
    logic                memwrite;
    logic                branch;
    logic                ubranch;
    logic [ALUOP_W-1:0]  aluop;
    logic                ir_write;
    logic                pc_write;
    logic                pc_sel;
    logic                trap;
    logic [1:0]          err_code;
    logic [RET_W-1:0]    retired;

    modport master (
        output opcode, ins_valid, zero, mem_ready, trap_clr,
        input  ins_ready, reg2loc, alusrc, memtoreg, regwrite, memread, memwrite,
               branch, ubranch, aluop, ir_write, pc_write, pc_sel, trap, err_code, retired
    );

    modport slave (
        input  opcode, ins_valid, zero, mem_ready, trap_clr,
        output ins_ready, reg2loc, alusrc, memtoreg, regwrite, memread, memwrite,
               branch, ubranch, aluop, ir_write, pc_write, pc_sel, trap, err_code, retired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for a small ARMv8 subset (R-type, LDUR, STUR, CBZ, B).
// Controls are decoded from the state register and the latched opcode.
module multicycle_control_unit #(
    parameter int OPCODE_W = 11,
    parameter int ALUOP_W  = 2,
    parameter int TMO_W    = 4,
    parameter int MEM_TMO  = 12,
    parameter int RET_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_control_unit_if.slave bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE = 3'd0,
        C_LOAD  = 3'd1,
        C_STORE = 3'd2,
        C_CBZ   = 3'd3,
        C_B     = 3'd4,
        C_ILL   = 3'd5
    } cls_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

    function automatic cls_t classify(input logic [10:0] op);
        cls_t c;
        casez (op)
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: c = C_RTYPE;
            11'b11111000010:                  c = C_LOAD;
            11'b11111000000:                  c = C_STORE;
            11'b10110100???:                  c = C_CBZ;
            11'b000101?????:                  c = C_B;
            default:                          c = C_ILL;
        endcase
        return c;
    endfunction

    state_t              state_r, next_state_s;
    logic [OPCODE_W-1:0] opcode_r;
    logic [10:0]         op11_s;
    cls_t                cls_s;
    logic [TMO_W-1:0]    tmo_cnt_r;
    logic [1:0]          err_r;
    logic [RET_W-1:0]    retired_r;

    logic               ins_ready_s, ir_write_s, reg2loc_s, alusrc_s, memtoreg_s;
    logic               regwrite_s, memread_s, memwrite_s, branch_s, ubranch_s;
    logic               pc_write_s, pc_sel_s, trap_s;
    logic [ALUOP_W-1:0] aluop_s;

    assign op11_s = 11'(opcode_r);
    assign cls_s  = classify(op11_s);

    // Next-state and control decode from state plus latched opcode class
    always_comb begin
        next_state_s = state_r;
        ins_ready_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg2loc_s    = 1'b0;
        alusrc_s     = 1'b0;
        memtoreg_s   = 1'b0;
        regwrite_s   = 1'b0;
        memread_s    = 1'b0;
        memwrite_s   = 1'b0;
        branch_s     = 1'b0;
        ubranch_s    = 1'b0;
        pc_write_s   = 1'b0;
        pc_sel_s     = 1'b0;
        trap_s       = 1'b0;
        aluop_s      = '0;
        case (state_r)
            S_FETCH: begin
                ins_ready_s = 1'b1;
                if (bus.ins_valid) begin
                    ir_write_s   = 1'b1;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (cls_s == C_ILL) begin
                    next_state_s = S_TRAP;
                end else begin
                    next_state_s = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_s)
                    C_RTYPE: begin
                        aluop_s      = ALUOP_W'(2'b10);
                        next_state_s = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alusrc_s     = 1'b1;
                        reg2loc_s    = 1'b1;
                        next_state_s = S_MEM;
                    end
                    C_CBZ: begin
                        aluop_s      = ALUOP_W'(2'b01);
                        reg2loc_s    = 1'b1;
                        branch_s     = 1'b1;
                        pc_write_s   = 1'b1;
                        pc_sel_s     = bus.zero;
                        next_state_s = S_FETCH;
                    end
                    C_B: begin
                        ubranch_s    = 1'b1;
                        pc_write_s   = 1'b1;
                        pc_sel_s     = 1'b1;
                        next_state_s = S_FETCH;
                    end
                    default: next_state_s = S_FETCH;
                endcase
            end
            S_MEM: begin
                memread_s  = (cls_s == C_LOAD);
                memwrite_s = (cls_s == C_STORE);
                // Completion on the limit cycle wins over the timeout
                if (bus.mem_ready) begin
                    if (cls_s == C_LOAD) begin
                        next_state_s = S_WB;
                    end else begin
                        pc_write_s   = (cls_s == C_STORE);
                        next_state_s = S_FETCH;
                    end
                end else if (tmo_cnt_r == TMO_LAST) begin
                    next_state_s = S_TRAP;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB: begin
                regwrite_s   = 1'b1;
                memtoreg_s   = (cls_s == C_LOAD);
                pc_write_s   = 1'b1;
                next_state_s = S_FETCH;
            end
            S_TRAP: begin
                trap_s = 1'b1;
                if (bus.trap_clr) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_TRAP;
                end
            end
            default: next_state_s = S_FETCH;
        endcase
    end

    // State, latched opcode, memory timeout, error code and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            opcode_r  <= '0;
            tmo_cnt_r <= '0;
            err_r     <= 2'b00;
            retired_r <= '0;
        end else begin
            state_r <= next_state_s;
            if (ir_write_s) begin
                opcode_r <= bus.opcode;
            end
            if (state_r != S_MEM) begin
                tmo_cnt_r <= '0;
            end else if (!bus.mem_ready) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
            if (next_state_s == S_TRAP && state_r != S_TRAP) begin
                err_r <= (state_r == S_DECODE) ? 2'b01 : 2'b10;
            end else if (state_r == S_TRAP && bus.trap_clr) begin
                err_r <= 2'b00;
            end
            if (pc_write_s) begin
                retired_r <= retired_r + RET_W'(1);
            end
        end
    end

    // FETCH is the reset state, so the fetch handshake is gated by rst_n itself
    assign bus.ins_ready = ins_ready_s & rst_n;
    assign bus.ir_write  = ir_write_s & rst_n;
    assign bus.reg2loc   = reg2loc_s;
    assign bus.alusrc    = alusrc_s;
    assign bus.memtoreg  = memtoreg_s;
    assign bus.regwrite  = regwrite_s;
    assign bus.memread   = memread_s;
    assign bus.memwrite  = memwrite_s;
    assign bus.branch    = branch_s;
    assign bus.ubranch   = ubranch_s;
    assign bus.aluop     = aluop_s;
    assign bus.pc_write  = pc_write_s;
    assign bus.pc_sel    = pc_sel_s;
    assign bus.trap      = trap_s;
    assign bus.err_code  = err_r;
    assign bus.retired   = retired_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed and random instructions against a per-cycle
// control-sequence model; a second RET_W=2 instance runs in lockstep for wrap checks.
module tb_multicycle_control_unit;

    localparam int MEM_TMO = 12;

    localparam logic [16:0] RDY    = 17'h10000;
    localparam logic [16:0] IRW    = 17'h08000;
    localparam logic [16:0] R2L    = 17'h04000;
    localparam logic [16:0] ASRC   = 17'h02000;
    localparam logic [16:0] M2R    = 17'h01000;
    localparam logic [16:0] RW     = 17'h00800;
    localparam logic [16:0] MR     = 17'h00400;
    localparam logic [16:0] MW     = 17'h00200;
    localparam logic [16:0] BR     = 17'h00100;
    localparam logic [16:0] UB     = 17'h00080;
    localparam logic [16:0] AL_R   = 17'h00040;
    localparam logic [16:0] AL_CBZ = 17'h00020;
    localparam logic [16:0] PCW    = 17'h00010;
    localparam logic [16:0] PCS    = 17'h00008;
    localparam logic [16:0] TRP    = 17'h00004;
    localparam logic [16:0] E_TMO  = 17'h00002;
    localparam logic [16:0] E_ILL  = 17'h00001;
    localparam logic [16:0] NONE   = 17'h00000;

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

    logic clk;
    logic rst_n;
    int   vectors    = 0;
    int   miscompares = 0;
    int   model_ret  = 0;

    multicycle_control_unit_if #(.OPCODE_W(11), .ALUOP_W(2), .RET_W(16)) bus ();
    multicycle_control_unit_if #(.OPCODE_W(11), .ALUOP_W(2), .RET_W(2))  bus2 ();

    assign bus2.opcode    = bus.opcode;
    assign bus2.ins_valid = bus.ins_valid;
    assign bus2.zero      = bus.zero;
    assign bus2.mem_ready = bus.mem_ready;
    assign bus2.trap_clr  = bus.trap_clr;

    multicycle_control_unit #(.OPCODE_W(11), .ALUOP_W(2), .TMO_W(4), .MEM_TMO(MEM_TMO), .RET_W(16))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    multicycle_control_unit #(.OPCODE_W(11), .ALUOP_W(2), .TMO_W(4), .MEM_TMO(MEM_TMO), .RET_W(2))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [16:0] obs, obs2;
    assign obs  = {bus.ins_ready, bus.ir_write, bus.reg2loc, bus.alusrc, bus.memtoreg,
                   bus.regwrite, bus.memread, bus.memwrite, bus.branch, bus.ubranch,
                   bus.aluop, bus.pc_write, bus.pc_sel, bus.trap, bus.err_code};
    assign obs2 = {bus2.ins_ready, bus2.ir_write, bus2.reg2loc, bus2.alusrc, bus2.memtoreg,
                   bus2.regwrite, bus2.memread, bus2.memwrite, bus2.branch, bus2.ubranch,
                   bus2.aluop, bus2.pc_write, bus2.pc_sel, bus2.trap, bus2.err_code};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int kind_of(input logic [10:0] op);
        if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) return K_R;
        if (op == 11'h7C2) return K_LD;
        if (op == 11'h7C0) return K_ST;
        if ((op & 11'h7F8) == 11'h5A0) return K_CBZ;
        if ((op & 11'h7E0) == 11'h0A0) return K_B;
        return K_ILL;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // One clock cycle: compare both instances at the falling edge, then move past the next rise
    task automatic step(input string tag, input logic [16:0] e);
        @(negedge clk);
        chk(tag, 32'(obs), 32'(e));
        chk({tag, "_w2"}, 32'(obs2), 32'(e));
        chk("retired", 32'(bus.retired), 32'(model_ret % 65536));
        chk("retired_w2", 32'(bus2.retired), 32'(model_ret % 4));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_trap(input logic [16:0] err, input int hold);
        bus.trap_clr = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.ins_valid = 1'(($urandom() & 1) != 0);
            step("trap_hold", TRP | err);
        end
        bus.ins_valid = 1'b0;
        bus.trap_clr  = 1'b1;
        step("trap_clr", TRP | err);
        bus.trap_clr  = 1'b0;
    endtask

    // w = mem_ready wait cycles; w >= MEM_TMO means mem_ready never comes
    task automatic run_instr(input logic [10:0] opc, input int w, input bit zv, input int idle);
        int k;
        logic [16:0] strobe;
        k = kind_of(opc);
        bus.ins_valid = 1'b0;
        bus.mem_ready = 1'b0;
        bus.trap_clr  = 1'b0;
        for (int i = 0; i < idle; i++) begin
            bus.opcode = 11'($urandom());
            step("idle", RDY);
        end
        bus.opcode    = opc;
        bus.ins_valid = 1'b1;
        step("fetch", RDY | IRW);
        bus.ins_valid = 1'b0;
        bus.opcode    = 11'($urandom());
        step("decode", NONE);
        bus.zero = zv;
        case (k)
            K_ILL: clear_trap(E_ILL, int'($urandom_range(0, 2)));
            K_R: begin
                step("exec_r", AL_R);
                bus.zero = 1'(($urandom() & 1) != 0);
                step("wb_r", RW | PCW);
                model_ret++;
            end
            K_B: begin
                step("exec_b", UB | PCW | PCS);
                model_ret++;
            end
            K_CBZ: begin
                step("exec_cbz", AL_CBZ | R2L | BR | PCW | (zv ? PCS : NONE));
                model_ret++;
            end
            default: begin
                strobe = (k == K_LD) ? MR : MW;
                step("exec_mem", ASRC | R2L);
                for (int i = 0; i < MEM_TMO; i++) begin
                    if (i == w) begin
                        bus.mem_ready = 1'b1;
                        if (k == K_LD) begin
                            step("mem_done_ld", MR);
                            bus.mem_ready = 1'b0;
                            step("wb_ld", RW | M2R | PCW);
                        end else begin
                            step("mem_done_st", MW | PCW);
                            bus.mem_ready = 1'b0;
                        end
                        model_ret++;
                        return;
                    end
                    step("mem_wait", strobe);
                end
                clear_trap(E_TMO, int'($urandom_range(0, 2)));
            end
        endcase
    endtask

    initial begin
        logic [10:0] opc;
        rst_n          = 1'b0;
        bus.opcode     = 11'h000;
        bus.ins_valid  = 1'b1;
        bus.zero       = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.trap_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(obs), 32'(NONE));
        chk("reset_retired", 32'(bus.retired), 32'd0);
        bus.ins_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("first_fetch", 32'(obs), 32'(RDY));

        // Retire counter wrap on the narrow instance: 1,2,3,0
        for (int i = 0; i < 4; i++) run_instr(11'h0A0 | 11'(i), 0, 1'b0, 0);

        run_instr(11'h458, 0, 1'b0, 0);             // ADD
        run_instr(11'h7C2, 2, 1'b0, 1);             // LDUR, two waits
        run_instr(11'h5A5, 0, 1'b1, 0);             // CBZ taken
        run_instr(11'h5A5, 0, 1'b0, 0);             // CBZ not taken
        run_instr(11'h000, 0, 1'b0, 0);             // illegal
        run_instr(11'h7C0, MEM_TMO, 1'b0, 0);       // STUR timeout
        run_instr(11'h7C0, MEM_TMO - 1, 1'b0, 0);   // STUR ready on limit cycle
        run_instr(11'h7C2, MEM_TMO - 1, 1'b0, 0);   // LDUR ready on limit cycle
        run_instr(11'h658, 0, 1'b0, 2);             // SUB
        run_instr(11'h450, 0, 1'b1, 0);             // AND
        run_instr(11'h550, 0, 1'b0, 0);             // ORR
        run_instr(11'h7C0, 0, 1'b0, 0);             // STUR, no wait

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 7))
                0: opc = 11'h458;
                1: opc = 11'h7C2;
                2: opc = 11'h7C0;
                3: opc = 11'h5A0 | 11'($urandom_range(0, 7));
                4: opc = 11'h0A0 | 11'($urandom_range(0, 31));
                5: begin
                    case ($urandom_range(0, 2))
                        0: opc = 11'h658;
                        1: opc = 11'h450;
                        default: opc = 11'h550;
                    endcase
                end
                default: opc = 11'($urandom());
            endcase
            run_instr(opc, int'($urandom_range(0, MEM_TMO)), 1'(($urandom() & 1) != 0),
                      int'($urandom_range(0, 2)));
        end

        // Reset while LDUR waits in MEM: strobes drop at once, nothing retires
        bus.opcode    = 11'h7C2;
        bus.ins_valid = 1'b1;
        step("rst_fetch", RDY | IRW);
        bus.ins_valid = 1'b0;
        step("rst_decode", NONE);
        step("rst_exec", ASRC | R2L);
        bus.mem_ready = 1'b0;
        step("rst_mem0", MR);
        #2;
        chk("pre_reset_memread", 32'(obs), 32'(MR));
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'(obs), 32'(NONE));
        chk("async_reset_w2", 32'(obs2), 32'(NONE));
        chk("async_reset_retired", 32'(bus.retired), 32'd0);
        chk("async_reset_retired_w2", 32'(bus2.retired), 32'd0);
        model_ret = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_fetch", 32'(obs), 32'(RDY));
        run_instr(11'h0A0, 0, 1'b0, 0);
        run_instr(11'h458, 0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
